// File: rtl/spi_wb_cmd_sequencer_if.sv
// Bundle of the command/response handshake and the Wishbone master bus
// around spi_wb_cmd_sequencer. "master" is the sequencer's view, "slave"
// is the view of the surrounding logic and the Wishbone slave.
interface spi_wb_cmd_sequencer_if;
    // command side
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [7:0] cmd_adr;
    logic [7:0] cmd_dat;
    // response side
    logic       rsp_valid;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic       busy;
    // Wishbone classic master
    logic       CYC_O;
    logic       STB_O;
    logic       WE_O;
    logic [7:0] ADR_O;
    logic [7:0] DAT_O;
    logic [7:0] DAT_I;
    logic       ACK_I;
    logic       RTY_I;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I, RTY_I,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
               CYC_O, STB_O, WE_O, ADR_O, DAT_O
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, DAT_I, ACK_I, RTY_I,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
               CYC_O, STB_O, WE_O, ADR_O, DAT_O
    );
endinterface

// File: rtl/spi_wb_cmd_sequencer.sv
// Wishbone master feeding the SPI master's Wishbone slave port. Commands are
// buffered in a small FIFO, each one becomes a classic Wishbone cycle with
// bounded RTY_I retry/backoff, and each produces exactly one response.
// Optional watchdog on the Wishbone cycle: define WB_TIMEOUT_EN.
module spi_wb_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_RETRY      = 8,
    parameter int BACKOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                    CLK_I,
    input logic                    RST_I,
    spi_wb_cmd_sequencer_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("FIFO_DEPTH must be a power of two >= 2");
    if (MAX_RETRY < 1 || MAX_RETRY > 255)
        $error("MAX_RETRY must be 1..255");
    if (BACKOFF_CYCLES < 1 || BACKOFF_CYCLES > 255)
        $error("BACKOFF_CYCLES must be 1..255");
    if (TIMEOUT_CYCLES < 1)
        $error("TIMEOUT_CYCLES must be >= 1");

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF, RESP} state_t;

    state_t          state, state_d;
    logic [16:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count, count_d;
    logic            cmd_ready_q;
    logic            push, pop;
    logic            hold_we;
    logic [7:0]      hold_adr, hold_dat;
    logic [7:0]      retry_cnt;
    logic [7:0]      boff_cnt;
    logic            stb_q, stb_d;
    logic            rsp_valid_q;
    logic [7:0]      rsp_dat_q;
    logic            rsp_err_q;
    logic            ack_hit, rty_hit, rty_last, timeout_hit;

    // Terminations only count while the strobe is actually on the bus;
    // ACK_I beats RTY_I when both arrive together.
    assign push     = bus.cmd_valid & cmd_ready_q;
    assign ack_hit  = stb_q & bus.ACK_I;
    assign rty_hit  = stb_q & bus.RTY_I & ~bus.ACK_I;
    assign rty_last = rty_hit && (retry_cnt == 8'(MAX_RETRY - 1));

`ifdef WB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    assign timeout_hit = stb_q && (wd_cnt == WW'(TIMEOUT_CYCLES - 1))
                         && !bus.ACK_I && !bus.RTY_I;

    // Watchdog: counts strobe-high clocks of the current attempt.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I)
            wd_cnt <= '0;
        else if (stb_q && state == REQ)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Occupancy after this clock's push/pop.
    always_comb begin
        count_d = count;
        if (push && !pop)
            count_d = count + 1'b1;
        else if (!push && pop)
            count_d = count - 1'b1;
    end

    // Next state; the strobe rises one clock after leaving IDLE, but
    // immediately when returning from BACKOFF so the gap is exact.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_hit || rty_last || timeout_hit)
                    state_d = RESP;
                else if (rty_hit)
                    state_d = BACKOFF;
            end
            BACKOFF: begin
                if (boff_cnt == '0)
                    state_d = REQ;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stb_d = (state_d == REQ) && (state != IDLE);
    end

    // FIFO storage: data only, flushing is done through the pointers.
    always_ff @(posedge CLK_I) begin
        if (push)
            fifo_mem[wr_ptr] <= {bus.cmd_we, bus.cmd_adr, bus.cmd_dat};
    end

    // Control state, FIFO pointers, holding and response registers.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cmd_ready_q <= 1'b0;
            hold_we     <= 1'b0;
            hold_adr    <= '0;
            hold_dat    <= '0;
            retry_cnt   <= '0;
            boff_cnt    <= '0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            cmd_ready_q <= (count_d != (AW+1)'(FIFO_DEPTH));
            stb_q       <= stb_d;
            rsp_valid_q <= (state_d == RESP);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                {hold_we, hold_adr, hold_dat} <= fifo_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                retry_cnt <= '0;
            end
            if (rty_hit) begin
                retry_cnt <= retry_cnt + 1'b1;
                boff_cnt  <= 8'(BACKOFF_CYCLES - 1);
            end else if (state == BACKOFF && boff_cnt != '0) begin
                boff_cnt <= boff_cnt - 1'b1;
            end
            if (ack_hit) begin
                rsp_dat_q <= hold_we ? hold_dat : bus.DAT_I;
                rsp_err_q <= 1'b0;
            end else if (rty_last || timeout_hit) begin
                rsp_dat_q <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (count != '0) || (state != IDLE);
    assign bus.CYC_O     = stb_q;
    assign bus.STB_O     = stb_q;
    assign bus.WE_O      = hold_we;
    assign bus.ADR_O     = hold_adr;
    assign bus.DAT_O     = hold_dat;

endmodule

// File: tb/tb_spi_wb_cmd_sequencer.sv
// Directed bench for spi_wb_cmd_sequencer: write, read, retry, retry
// exhaustion, FIFO full/ordering, reset mid-cycle and (with WB_TIMEOUT_EN)
// the watchdog. Inputs change and outputs are sampled on the falling edge.
module tb_spi_wb_cmd_sequencer;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK_I = ~CLK_I;

    spi_wb_cmd_sequencer_if bus_if ();

    spi_wb_cmd_sequencer #(
        .FIFO_DEPTH    (4),
        .MAX_RETRY     (8),
        .BACKOFF_CYCLES(16),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .bus  (bus_if.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic we, input logic [7:0] adr, input logic [7:0] dat);
        bit acc = 1'b0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_we    = we;
        bus_if.cmd_adr   = adr;
        bus_if.cmd_dat   = dat;
        for (int n = 0; n < 200 && !acc; n++) begin
            acc = bus_if.cmd_ready;
            @(negedge CLK_I);
        end
        bus_if.cmd_valid = 1'b0;
        check("push_accept", acc, 1);
    endtask

    task automatic wait_stb(output int lowcyc);
        lowcyc = 0;
        while (bus_if.STB_O !== 1'b1 && lowcyc < 1000) begin
            @(negedge CLK_I);
            lowcyc++;
        end
        check("stb_seen", bus_if.STB_O, 1);
    endtask

    task automatic answer(input logic ack, input logic rty, input logic [7:0] d);
        bus_if.ACK_I = ack;
        bus_if.RTY_I = rty;
        bus_if.DAT_I = d;
        @(negedge CLK_I);
        bus_if.ACK_I = 1'b0;
        bus_if.RTY_I = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  g;
        int  att;
        bit  rsp_seen, stb_seen;
        logic [7:0] exp_dat [5];

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = '0;
        bus_if.cmd_dat   = '0;
        bus_if.DAT_I     = '0;
        bus_if.ACK_I     = 1'b0;
        bus_if.RTY_I     = 1'b0;

        // reset state
        repeat (2) @(negedge CLK_I);
        check("rst_cmd_ready", bus_if.cmd_ready, 0);
        check("rst_cyc", bus_if.CYC_O, 0);
        check("rst_stb", bus_if.STB_O, 0);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_rsp_dat", bus_if.rsp_dat, 0);
        check("rst_busy", bus_if.busy, 0);
        RST_I = 1'b1;
        @(negedge CLK_I);
        check("post_rst_ready", bus_if.cmd_ready, 1);

        // write, ACK on the third strobe clock
        push(1'b1, 8'h10, 8'hA5);
        check("wr_stb_e0", bus_if.STB_O, 0);
        @(negedge CLK_I);
        check("wr_stb_e1", bus_if.STB_O, 0);
        @(negedge CLK_I);
        check("wr_stb_e2", bus_if.STB_O, 1);
        check("wr_cyc", bus_if.CYC_O, 1);
        check("wr_adr", bus_if.ADR_O, 8'h10);
        check("wr_dat_o", bus_if.DAT_O, 8'hA5);
        check("wr_we", bus_if.WE_O, 1);
        repeat (2) @(negedge CLK_I);
        check("wr_adr_hold", bus_if.ADR_O, 8'h10);
        check("wr_rsp_early", bus_if.rsp_valid, 0);
        answer(1'b1, 1'b0, 8'h00);
        check("wr_rsp_valid", bus_if.rsp_valid, 1);
        check("wr_rsp_dat", bus_if.rsp_dat, 8'hA5);
        check("wr_rsp_err", bus_if.rsp_err, 0);
        check("wr_stb_drop", bus_if.STB_O, 0);
        check("wr_busy_resp", bus_if.busy, 1);
        @(negedge CLK_I);
        check("wr_rsp_pulse", bus_if.rsp_valid, 0);
        check("wr_busy_fall", bus_if.busy, 0);
        check("wr_rsp_hold", bus_if.rsp_dat, 8'hA5);

        // read
        push(1'b0, 8'h01, 8'h00);
        wait_stb(g);
        check("rd_we", bus_if.WE_O, 0);
        check("rd_adr", bus_if.ADR_O, 8'h01);
        answer(1'b1, 1'b0, 8'h3C);
        check("rd_rsp_valid", bus_if.rsp_valid, 1);
        check("rd_rsp_dat", bus_if.rsp_dat, 8'h3C);
        check("rd_rsp_err", bus_if.rsp_err, 0);

        // ACK and RTY together: ACK wins
        push(1'b0, 8'h02, 8'h00);
        wait_stb(g);
        answer(1'b1, 1'b1, 8'h5E);
        check("ackrty_valid", bus_if.rsp_valid, 1);
        check("ackrty_dat", bus_if.rsp_dat, 8'h5E);
        check("ackrty_err", bus_if.rsp_err, 0);

        // two retries then ACK, 16 low clocks between attempts
        push(1'b1, 8'h20, 8'h77);
        wait_stb(g);
        answer(1'b0, 1'b1, 8'h00);
        check("rty1_no_rsp", bus_if.rsp_valid, 0);
        check("rty1_stb_low", bus_if.STB_O, 0);
        wait_stb(g);
        check("rty1_gap", g, 16);
        check("rty_adr_kept", bus_if.ADR_O, 8'h20);
        answer(1'b0, 1'b1, 8'h00);
        check("rty2_no_rsp", bus_if.rsp_valid, 0);
        wait_stb(g);
        check("rty2_gap", g, 16);
        answer(1'b1, 1'b0, 8'h00);
        check("rty_rsp_valid", bus_if.rsp_valid, 1);
        check("rty_rsp_err", bus_if.rsp_err, 0);
        check("rty_rsp_dat", bus_if.rsp_dat, 8'h77);

        // retry exhaustion, then the queued command proceeds
        push(1'b1, 8'h30, 8'h5A);
        push(1'b0, 8'h31, 8'h00);
        att = 0;
        for (int i = 0; i < 8; i++) begin
            wait_stb(g);
            att++;
            check("exh_adr", bus_if.ADR_O, 8'h30);
            answer(1'b0, 1'b1, 8'h00);
            check("exh_rsp_valid", bus_if.rsp_valid, (i == 7) ? 1 : 0);
        end
        check("exh_attempts", att, 8);
        check("exh_err", bus_if.rsp_err, 1);
        check("exh_dat", bus_if.rsp_dat, 8'h00);
        wait_stb(g);
        check("exh_next_adr", bus_if.ADR_O, 8'h31);
        answer(1'b1, 1'b0, 8'hC3);
        check("exh_next_valid", bus_if.rsp_valid, 1);
        check("exh_next_dat", bus_if.rsp_dat, 8'hC3);
        check("exh_next_err", bus_if.rsp_err, 0);

        // FIFO full and ordering: ACK held low while five commands go in
        for (int i = 0; i < 5; i++) begin
            exp_dat[i] = 8'(8'h11 * (i + 1));
            push(1'b1, 8'(8'h40 + i), exp_dat[i]);
        end
        check("full_ready", bus_if.cmd_ready, 0);
        check("full_busy", bus_if.busy, 1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_adr   = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_I);
            check("full_ready_hold", bus_if.cmd_ready, 0);
        end
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_stb(g);
            check("ord_adr", bus_if.ADR_O, 8'(8'h40 + i));
            answer(1'b1, 1'b0, 8'h00);
            check("ord_rsp_valid", bus_if.rsp_valid, 1);
            check("ord_rsp_dat", bus_if.rsp_dat, exp_dat[i]);
        end
        repeat (3) @(negedge CLK_I);
        check("ord_busy_end", bus_if.busy, 0);
        check("ord_ready_end", bus_if.cmd_ready, 1);

        // reset in the middle of a cycle
        push(1'b1, 8'h50, 8'hAA);
        wait_stb(g);
        RST_I = 1'b0;
        #1;
        check("mrst_stb", bus_if.STB_O, 0);
        check("mrst_cyc", bus_if.CYC_O, 0);
        check("mrst_busy", bus_if.busy, 0);
        check("mrst_rsp_valid", bus_if.rsp_valid, 0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        rsp_seen = 1'b0;
        stb_seen = 1'b0;
        repeat (10) begin
            @(negedge CLK_I);
            rsp_seen |= bus_if.rsp_valid;
            stb_seen |= bus_if.STB_O;
        end
        check("mrst_no_rsp", rsp_seen, 0);
        check("mrst_no_stb", stb_seen, 0);
        check("mrst_ready", bus_if.cmd_ready, 1);

`ifdef WB_TIMEOUT_EN
        // watchdog: no termination at all
        push(1'b0, 8'h60, 8'h00);
        wait_stb(g);
        att = 0;
        while (bus_if.STB_O === 1'b1 && att < 1000) begin
            att++;
            @(negedge CLK_I);
        end
        check("to_stb_clocks", att, 255);
        check("to_rsp_valid", bus_if.rsp_valid, 1);
        check("to_rsp_err", bus_if.rsp_err, 1);
        check("to_rsp_dat", bus_if.rsp_dat, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_wb_cmd_sequencer.md
Name: spi_wb_cmd_sequencer

Overview:
Wishbone master that feeds the SPI master's Wishbone slave port.
- Accepts byte-level commands (address, data, read/write) on a valid/ready interface and buffers them in a small FIFO.
- Issues one classic Wishbone cycle per command.
- Handles RTY_I with bounded retry and backoff.
- Returns one response per command (read data or echoed write data, plus an error flag) to the controlling logic.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.
- MAX_RETRY, 8, RTY_I responses tolerated per command before it is reported as an error; 1..255.
- BACKOFF_CYCLES, 16, idle clocks between an RTY_I and the re-issue; 1..255.
- TIMEOUT_CYCLES, 255, watchdog limit in clocks; used only with WB_TIMEOUT_EN.

Ports:
- CLK_I  in  1  system clock, all logic on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  8  Wishbone address.
- cmd_dat  in  8  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_dat  out  8  read data (reads) or echoed cmd_dat (writes).
- rsp_err  out  1  command failed (retries exhausted or timeout).
- busy  out  1  FIFO non-empty or FSM not IDLE.
- CYC_O, STB_O, WE_O  out  1  Wishbone master controls.
- ADR_O  out  8  Wishbone address.
- DAT_O  out  8  Wishbone write data.
- DAT_I  in  8  Wishbone read data.
- ACK_I, RTY_I  in  1  Wishbone terminations.

Behaviour:
- Reset (RST_I low, takes effect immediately):
  - FIFO flushed; retry, backoff and watchdog counters = 0; FSM = IDLE.
  - All outputs 0, except cmd_ready = 1 once reset deasserts.
  - Reset mid-cycle drops CYC_O/STB_O at once; the in-flight command is lost and gets no response.
- FIFO:
  - Entry is 17 bits {we, adr, dat].
  - Push on cmd_valid & cmd_ready. cmd_ready = !full, registered from the occupancy count.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, REQ, BACKOFF, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the holding registers, clear retry_cnt, go to REQ.
  - STB_O is asserted 2 clocks after the accepting edge of a command pushed into an empty FIFO while IDLE.
- REQ:
  - CYC_O = STB_O = 1; WE_O/ADR_O/DAT_O driven from the holding registers and held stable.
  - ACK_I: capture rsp_dat (DAT_I if read, held dat if write), rsp_err = 0, go to RESP.
  - RTY_I (without ACK_I):
    - Deassert CYC_O/STB_O next clock and increment retry_cnt.
    - If retry_cnt reaches MAX_RETRY: rsp_err = 1, rsp_dat = 0, go to RESP.
    - Otherwise load the backoff counter and go to BACKOFF.
  - ACK_I and RTY_I together: ACK_I wins.
- BACKOFF:
  - CYC_O = STB_O = 0; count down BACKOFF_CYCLES, then return to REQ.
  - Exactly BACKOFF_CYCLES clocks with STB_O low between attempts.
- RESP:
  - rsp_valid = 1 for exactly one clock; no backpressure.
  - rsp_dat/rsp_err hold until the next response.
  - Next state is IDLE; back-to-back commands therefore have at least one idle clock (IDLE) between STB_O pulses.
- Ordering: responses come back in command order, one per accepted command.
- busy = (count != 0) | (state != IDLE).

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - A watchdog counts clocks spent in REQ; it resets on entry to REQ.
  - If it reaches TIMEOUT_CYCLES with no ACK_I/RTY_I: drop CYC_O/STB_O, rsp_err = 1, rsp_dat = 0, go to RESP.
  - A termination arriving on the same clock as expiry wins over the timeout.
- Undefined: no watchdog logic; REQ waits indefinitely for ACK_I or RTY_I.

Test Plan:
- Write: push {we=1, adr=0x10, dat=0xA5}; slave ACKs on the 3rd STB_O clock -> ADR_O = 0x10, DAT_O = 0xA5, WE_O = 1 through the cycle; rsp_valid 1 clock with rsp_dat = 0xA5, rsp_err = 0; busy falls the clock after.
- Read: push {we=0, adr=0x01}; slave returns DAT_I = 0x3C with ACK_I -> rsp_dat = 0x3C, rsp_err = 0.
- Retry: slave RTYs twice then ACKs, BACKOFF_CYCLES = 16 -> three STB_O assertions separated by exactly 16 low clocks; single response with rsp_err = 0.
- Retry exhaustion: slave always RTYs, MAX_RETRY = 8 -> exactly 8 STB_O attempts, then rsp_err = 1, rsp_dat = 0x00; next queued command proceeds.
- FIFO full and ordering: hold ACK_I low, push 5 commands with FIFO_DEPTH = 4 -> cmd_ready low after 4 accepted (first already popped into REQ, so 5 total accepted); release ACK_I -> 5 responses in push order.
- Reset and timeout: assert RST_I low during REQ -> CYC_O/STB_O = 0 immediately, busy = 0, no rsp_valid. With WB_TIMEOUT_EN, TIMEOUT_CYCLES = 255 and no termination -> STB_O high for 255 clocks, then rsp_err = 1.
